// File: rtl/usb_tx_encoder_if.sv
// Byte-side handshake and D+/D- line outputs of the full-speed USB transmit encoder.
// The packet controller uses the master modport; the encoder uses the slave modport.
interface usb_tx_encoder_if;
   logic       tx_start;
   logic [7:0] tx_pid;
   logic       packet_type;
   logic       tx_nodata;
   logic [7:0] tx_data;
   logic       tx_data_valid;
   logic       tx_last;
   logic       tx_data_ready;
   logic       d_plus_out;
   logic       d_minus_out;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_error;

   modport master (
      output tx_start, tx_pid, packet_type, tx_nodata, tx_data, tx_data_valid, tx_last,
      input  tx_data_ready, d_plus_out, d_minus_out, tx_busy, tx_done, tx_error
   );

   modport slave (
      input  tx_start, tx_pid, packet_type, tx_nodata, tx_data, tx_data_valid, tx_last,
      output tx_data_ready, d_plus_out, d_minus_out, tx_busy, tx_done, tx_error
   );
endinterface

// File: rtl/usb_tx_encoder.sv
// Full-speed USB packet transmitter: SYNC, PID, payload, CRC16, bit stuffing, NRZI, EOP.
// Optional CRC16 generation is compiled in when USB_TX_CRC16_EN is defined.
module usb_tx_encoder #(
   parameter int CLKS_PER_BIT = 8
) (
   input logic             clk,
   input logic             rst,
   usb_tx_encoder_if.slave bus
);
   // state     | meaning
   // S_IDLE    | lines at J, waiting for tx_start
   // S_SYNC    | sending 8'h80 LSB first
   // S_PID     | sending the PID byte
   // S_DATA    | sending payload bytes, CRC accumulating
   // S_CRC     | sending inverted CRC16
   // S_EOP_SE0 | two bit times of SE0
   // S_EOP_J   | one bit time of J, then tx_done
   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J
   } state_t;

   localparam int            CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CLKS_M1 = CW'(CLKS_PER_BIT - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic [7:0]    pid_q, pid_d;
   logic [2:0]    ones_q, ones_d;
   logic          last_q, last_d;
   logic          data_pkt_q, data_pkt_d;
   logic          nodata_q, nodata_d;
   logic          dp_q, dp_d;
   logic          se0_q, se0_d;
   logic          done_q, done_d;
`ifdef USB_TX_CRC16_EN
   logic [15:0]   crc_q, crc_d;
   logic          crc_fb;
`endif
   logic          tc, emit, emit_bit, do_byte, do_end, do_eop, ready_c, error_c;

   always_comb begin
      state_d    = state_q;
      clk_cnt_d  = clk_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pid_d      = pid_q;
      ones_d     = ones_q;
      last_d     = last_q;
      data_pkt_d = data_pkt_q;
      nodata_d   = nodata_q;
      dp_d       = dp_q;
      se0_d      = se0_q;
      done_d     = 1'b0;
      emit       = 1'b0;
      emit_bit   = 1'b0;
      do_byte    = 1'b0;
      do_end     = 1'b0;
      do_eop     = 1'b0;
      ready_c    = 1'b0;
      error_c    = 1'b0;
`ifdef USB_TX_CRC16_EN
      crc_d      = crc_q;
      crc_fb     = 1'b0;
`endif
      tc = (clk_cnt_q == '0);
      if (state_q != S_IDLE)
         clk_cnt_d = tc ? CLKS_M1 : clk_cnt_q - 1'b1;

      case (state_q)
         S_IDLE: begin
            if (bus.tx_start && !done_q) begin
               state_d    = S_SYNC;
               clk_cnt_d  = CLKS_M1;
               pid_d      = bus.tx_pid;
               data_pkt_d = bus.packet_type;
               nodata_d   = bus.tx_nodata;
               bit_cnt_d  = 4'd0;
               shift_d    = 8'h40;
               emit       = 1'b1;
`ifdef USB_TX_CRC16_EN
               crc_d      = 16'hFFFF;
`endif
            end
         end
         S_SYNC, S_PID, S_DATA, S_CRC: begin
            if (tc) begin
               // a pending stuff bit always wins over advancing the bit position
               if (ones_q == 3'd6) begin
                  dp_d   = ~dp_q;
                  ones_d = 3'd0;
               end else if (state_q != S_CRC && bit_cnt_q != 4'd7) begin
                  emit      = 1'b1;
                  emit_bit  = shift_q[0];
                  shift_d   = shift_q >> 1;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else begin
                  case (state_q)
                     S_SYNC: begin
                        state_d   = S_PID;
                        bit_cnt_d = 4'd0;
                        emit      = 1'b1;
                        emit_bit  = pid_q[0];
                        shift_d   = pid_q >> 1;
                     end
                     S_PID: begin
                        if (!data_pkt_q)   do_eop  = 1'b1;
                        else if (nodata_q) do_end  = 1'b1;
                        else               do_byte = 1'b1;
                     end
                     S_DATA: begin
                        if (last_q) do_end  = 1'b1;
                        else        do_byte = 1'b1;
                     end
                     default: begin
`ifdef USB_TX_CRC16_EN
                        if (bit_cnt_q != 4'd15) begin
                           emit      = 1'b1;
                           emit_bit  = ~crc_q[0];
                           crc_d     = crc_q >> 1;
                           bit_cnt_d = bit_cnt_q + 4'd1;
                        end else begin
                           do_eop = 1'b1;
                        end
`else
                        do_eop = 1'b1;
`endif
                     end
                  endcase
               end
            end
         end
         S_EOP_SE0: begin
            if (tc) begin
               if (bit_cnt_q == 4'd0) begin
                  bit_cnt_d = 4'd1;
               end else begin
                  state_d = S_EOP_J;
                  se0_d   = 1'b0;
                  dp_d    = 1'b1;
               end
            end
         end
         S_EOP_J: begin
            if (tc) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (do_byte) begin
         if (bus.tx_data_valid) begin
            ready_c   = 1'b1;
            last_d    = bus.tx_last;
            state_d   = S_DATA;
            bit_cnt_d = 4'd0;
            emit      = 1'b1;
            emit_bit  = bus.tx_data[0];
            shift_d   = bus.tx_data >> 1;
         end else begin
            error_c = 1'b1;
            do_eop  = 1'b1;
         end
      end

      if (do_end) begin
`ifdef USB_TX_CRC16_EN
         state_d   = S_CRC;
         bit_cnt_d = 4'd0;
         emit      = 1'b1;
         emit_bit  = ~crc_q[0];
         crc_d     = crc_q >> 1;
`else
         do_eop = 1'b1;
`endif
      end

      if (do_eop) begin
         state_d   = S_EOP_SE0;
         se0_d     = 1'b1;
         bit_cnt_d = 4'd0;
         ones_d    = 3'd0;
      end

      // NRZI: a 0 toggles the line, a 1 holds it
      if (emit) begin
         dp_d   = emit_bit ? dp_q : ~dp_q;
         ones_d = emit_bit ? ones_q + 3'd1 : 3'd0;
      end

`ifdef USB_TX_CRC16_EN
      // reflected form of 0x8005: shifts toward bit 0, so crc_q[0] is the next bit out
      crc_fb = emit_bit ^ crc_q[0];
      if (emit && state_d == S_DATA)
         crc_d = (crc_q >> 1) ^ (crc_fb ? 16'hA001 : 16'h0000);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         clk_cnt_q  <= '0;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         pid_q      <= 8'h00;
         ones_q     <= 3'd0;
         last_q     <= 1'b0;
         data_pkt_q <= 1'b0;
         nodata_q   <= 1'b0;
         dp_q       <= 1'b1;
         se0_q      <= 1'b0;
         done_q     <= 1'b0;
`ifdef USB_TX_CRC16_EN
         crc_q      <= 16'hFFFF;
`endif
      end else begin
         state_q    <= state_d;
         clk_cnt_q  <= clk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         pid_q      <= pid_d;
         ones_q     <= ones_d;
         last_q     <= last_d;
         data_pkt_q <= data_pkt_d;
         nodata_q   <= nodata_d;
         dp_q       <= dp_d;
         se0_q      <= se0_d;
         done_q     <= done_d;
`ifdef USB_TX_CRC16_EN
         crc_q      <= crc_d;
`endif
      end
   end

   assign bus.d_plus_out    = dp_q & ~se0_q;
   assign bus.d_minus_out   = ~dp_q & ~se0_q;
   assign bus.tx_busy       = (state_q != S_IDLE);
   assign bus.tx_done       = done_q;
   assign bus.tx_data_ready = ready_c;
   assign bus.tx_error      = error_c;
endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench for usb_tx_encoder: captures the D+/D- waveform, NRZI-decodes and
// destuffs it, and compares against packets built from hand-chosen vectors.
module tb_usb_tx_encoder;
   localparam int CPB  = 8;
   localparam int MAXC = 1000;
`ifdef USB_TX_CRC16_EN
   localparam bit CRC_EN = 1'b1;
`else
   localparam bit CRC_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   usb_tx_encoder_if bus();
   usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(bus));

   int         n_tests = 0;
   int         n_fail  = 0;
   logic       ln_dp [0:MAXC-1];
   logic       ln_dm [0:MAXC-1];
   int         done_cyc, rdy_cnt, err_cnt, pay_idx, pay_n;
   logic [7:0] pay [0:3];
   bit         pay_last;
   bit         exp_raw [0:127];
   int         exp_len;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_pay();
      if (pay_idx < pay_n) begin
         bus.tx_data_valid = 1'b1;
         bus.tx_data       = pay[pay_idx];
         bus.tx_last       = pay_last && (pay_idx == pay_n - 1);
      end else begin
         bus.tx_data_valid = 1'b0;
         bus.tx_data       = 8'h00;
         bus.tx_last       = 1'b0;
      end
   endtask

   task automatic run_pkt(input string nm, input logic [7:0] pid, input logic ptype,
                          input logic nodata, input int dup_at, input bit dup_done);
      bit adv = 1'b0;
      pay_idx  = 0;
      drive_pay();
      rdy_cnt  = 0;
      err_cnt  = 0;
      done_cyc = -1;
      @(negedge clk);
      bus.tx_pid      = pid;
      bus.packet_type = ptype;
      bus.tx_nodata   = nodata;
      bus.tx_start    = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
      for (int c = 0; c < MAXC; c++) begin
         if (c > 0) @(negedge clk);
         if (adv) begin
            pay_idx++;
            drive_pay();
            adv = 1'b0;
         end
         bus.tx_start = (c == dup_at);
         #1;
         ln_dp[c] = bus.d_plus_out;
         ln_dm[c] = bus.d_minus_out;
         if (bus.tx_data_ready) begin
            rdy_cnt++;
            adv = 1'b1;
         end
         if (bus.tx_error) err_cnt++;
         if (bus.tx_done) begin
            done_cyc = c;
            break;
         end
      end
      bus.tx_start = 1'b0;
      check_eq({nm, "/done_seen"}, longint'(done_cyc >= 0), 1);
      if (dup_done && done_cyc >= 0) begin
         bus.tx_start = 1'b1;
         @(negedge clk);
         bus.tx_start = 1'b0;
         repeat (3) @(negedge clk);
         #1;
         check_eq({nm, "/start_during_done"}, longint'(bus.tx_busy), 0);
      end
   endtask

   task automatic push(input bit b);
      exp_raw[exp_len] = b;
      exp_len++;
   endtask

   function automatic logic [15:0] crc_step(input logic [15:0] c, input bit b);
      logic fb;
      fb = b ^ c[15];
      return fb ? ((c << 1) ^ 16'h8005) : (c << 1);
   endfunction

   // expected unstuffed bit stream (SYNC, PID, payload, CRC) in transmit order
   task automatic build_exp(input logic [7:0] pid, input logic ptype, input logic nodata,
                            input bit underrun);
      logic [7:0]  v;
      logic [15:0] crc = 16'hFFFF;
      exp_len = 0;
      v = 8'h80;
      for (int i = 0; i < 8; i++) push(v[i]);
      for (int i = 0; i < 8; i++) push(pid[i]);
      if (ptype && !nodata)
         for (int j = 0; j < pay_n; j++) begin
            v = pay[j];
            for (int i = 0; i < 8; i++) begin
               push(v[i]);
               crc = crc_step(crc, v[i]);
            end
         end
      if (ptype && !underrun && CRC_EN)
         for (int i = 15; i >= 0; i--) push(~crc[i]);
   endtask

   task automatic analyze(input string nm);
      int         nb, glitch, k, ones, stuffed, stuff_err, line_err, raw_n, se0_at, exp_s;
      logic       prev, dec;
      logic [63:0] got_v, exp_v;
      logic [2:0] eop;
      if (done_cyc < 0) return;
      nb = done_cyc / CPB;
      check_eq({nm, "/bit_align"}, longint'(done_cyc % CPB), 0);
      glitch = 0;
      for (int c = 0; c < done_cyc; c++)
         if (ln_dp[c] !== ln_dp[c - c % CPB] || ln_dm[c] !== ln_dm[c - c % CPB]) glitch++;
      check_eq({nm, "/stable"}, longint'(glitch), 0);

      prev = 1'b1; ones = 0; stuffed = 0; stuff_err = 0; line_err = 0; raw_n = 0;
      got_v = '0; se0_at = nb;
      for (k = 0; k < nb; k++) begin
         if (!ln_dp[k*CPB + CPB/2] && !ln_dm[k*CPB + CPB/2]) begin
            se0_at = k;
            break;
         end
         if (ln_dp[k*CPB + CPB/2] === ln_dm[k*CPB + CPB/2]) line_err++;
         dec  = (ln_dp[k*CPB + CPB/2] == prev);
         prev = ln_dp[k*CPB + CPB/2];
         if (ones == 6) begin
            if (dec) stuff_err++;
            stuffed++;
            ones = 0;
         end else begin
            if (raw_n < 64) got_v[raw_n] = dec;
            raw_n++;
            ones = dec ? ones + 1 : 0;
         end
      end

      exp_v = '0; ones = 0; exp_s = 0;
      for (int i = 0; i < exp_len; i++) begin
         exp_v[i] = exp_raw[i];
         ones = exp_raw[i] ? ones + 1 : 0;
         if (ones == 6) begin
            exp_s++;
            ones = 0;
         end
      end

      check_eq({nm, "/raw_len"},   longint'(raw_n), longint'(exp_len));
      check_eq({nm, "/raw_bits"},  longint'(got_v), longint'(exp_v));
      check_eq({nm, "/stuffed"},   longint'(stuffed), longint'(exp_s));
      check_eq({nm, "/stuff_err"}, longint'(stuff_err + line_err), 0);
      eop = 3'b000;
      if (se0_at + 2 < nb) begin
         eop[2] = !ln_dp[se0_at*CPB + CPB/2]     && !ln_dm[se0_at*CPB + CPB/2];
         eop[1] = !ln_dp[(se0_at+1)*CPB + CPB/2] && !ln_dm[(se0_at+1)*CPB + CPB/2];
         eop[0] =  ln_dp[(se0_at+2)*CPB + CPB/2] && !ln_dm[(se0_at+2)*CPB + CPB/2];
      end
      check_eq({nm, "/eop"},   longint'(eop), 7);
      check_eq({nm, "/nbits"}, longint'(nb), longint'(exp_len + exp_s + 3));
   endtask

   task automatic check_ack(input string nm);
      logic [7:0] pat;
      build_exp(8'hD2, 1'b0, 1'b0, 1'b0);
      analyze(nm);
      check_eq({nm, "/done_at"}, longint'(done_cyc), 152);
      check_eq({nm, "/ready"},   longint'(rdy_cnt), 0);
      for (int k = 0; k < 8; k++) pat[7-k] = ln_dp[k*CPB + CPB/2];
      check_eq({nm, "/sync_lines"}, longint'(pat), 8'b01010100);
   endtask

   initial begin
      int dcnt, nj;
      bus.tx_start = 1'b0; bus.tx_pid = 8'h00; bus.packet_type = 1'b0; bus.tx_nodata = 1'b0;
      bus.tx_data = 8'h00; bus.tx_data_valid = 1'b0; bus.tx_last = 1'b0;
      pay_n = 0; pay_idx = 0; pay_last = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      check_eq("reset_vals", longint'({bus.d_plus_out, bus.d_minus_out, bus.tx_busy,
                                       bus.tx_done, bus.tx_error, bus.tx_data_ready}), 6'b100000);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);

      pay_n = 0;
      run_pkt("ack", 8'hD2, 1'b0, 1'b0, -1, 1'b0);
      check_ack("ack");

      run_pkt("zlp", 8'hC3, 1'b1, 1'b1, -1, 1'b0);
      build_exp(8'hC3, 1'b1, 1'b1, 1'b0);
      analyze("zlp");
      check_eq("zlp/len", longint'(done_cyc / CPB), CRC_EN ? 35 : 19);
      check_eq("zlp/ready", longint'(rdy_cnt), 0);

      pay[0] = 8'hFF; pay[1] = 8'hFF; pay_n = 2; pay_last = 1'b1;
      run_pkt("ffff", 8'h4B, 1'b1, 1'b0, -1, 1'b0);
      build_exp(8'h4B, 1'b1, 1'b0, 1'b0);
      analyze("ffff");
      check_eq("ffff/ready", longint'(rdy_cnt), 2);
      check_eq("ffff/error", longint'(err_cnt), 0);

      pay[0] = 8'h01; pay_n = 1; pay_last = 1'b0;
      run_pkt("urun", 8'hC3, 1'b1, 1'b0, -1, 1'b0);
      build_exp(8'hC3, 1'b1, 1'b0, 1'b1);
      analyze("urun");
      check_eq("urun/error", longint'(err_cnt), 1);
      check_eq("urun/ready", longint'(rdy_cnt), 1);
      check_eq("urun/nbits", longint'(done_cyc / CPB), 27);

      // reset while the first payload byte is on the lines
      pay[0] = 8'hFF; pay[1] = 8'hFF; pay_n = 2; pay_last = 1'b1; pay_idx = 0;
      drive_pay();
      @(negedge clk);
      bus.tx_pid = 8'h4B; bus.packet_type = 1'b1; bus.tx_nodata = 1'b0; bus.tx_start = 1'b1;
      @(negedge clk);
      bus.tx_start = 1'b0;
      repeat (150) @(negedge clk);
      #1;
      check_eq("rst/busy_before", longint'(bus.tx_busy), 1);
      rst = 1'b1;
      #1;
      check_eq("rst/outputs", longint'({bus.d_plus_out, bus.d_minus_out, bus.tx_busy,
                                        bus.tx_done, bus.tx_error, bus.tx_data_ready}), 6'b100000);
      @(negedge clk) rst = 1'b0;
      pay_n = 0; pay_idx = 0;
      drive_pay();
      dcnt = 0; nj = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         #1;
         if (bus.tx_done) dcnt++;
         if (!(bus.d_plus_out && !bus.d_minus_out)) nj++;
      end
      check_eq("rst/no_done", longint'(dcnt), 0);
      check_eq("rst/idle_j", longint'(nj), 0);
      run_pkt("rst_ack", 8'hD2, 1'b0, 1'b0, -1, 1'b0);
      check_ack("rst_ack");

      run_pkt("dup", 8'hD2, 1'b0, 1'b0, 40, 1'b1);
      check_ack("dup");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Full-speed USB packet transmitter, the transmit-direction counterpart of the USB receive path. It takes a PID and an optional stream of payload bytes, then drives the D+/D− pair with the complete packet: SYNC, PID, payload, CRC16, bit stuffing, NRZI encoding and EOP. It sits between the packet controller (byte source) and the USB pad drivers.

## Interface
- CLKS_PER_BIT, 8: clock cycles per USB bit time (≥2).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_start  in  1  one-cycle request; sampled only in IDLE.
- tx_pid  in  8  PID byte, sampled with tx_start.
- packet_type  in  1  sampled with tx_start; 0 = handshake (PID only), 1 = data (PID + payload + CRC).
- tx_nodata  in  1  sampled with tx_start; with packet_type=1, sends a zero-length data packet.
- tx_data  in  8  payload byte.
- tx_data_valid  in  1  tx_data holds a byte.
- tx_last  in  1  qualifies tx_data as the final payload byte.
- tx_data_ready  out  1  one-cycle pulse; the byte on tx_data is consumed this cycle.
- d_plus_out  out  1  D+ drive.
- d_minus_out  out  1  D− drive.
- tx_busy  out  1  high from the cycle after an accepted tx_start until tx_done.
- tx_done  out  1  one-cycle pulse after the EOP completes.
- tx_error  out  1  one-cycle pulse on payload underrun.

## Operation
- States: IDLE → SYNC → PID → DATA → CRC → EOP_SE0 → EOP_J → IDLE.
  - Handshake packets skip DATA and CRC.
  - Zero-length packets skip DATA.
- Bytes are sent LSB first. SYNC is 8'h80, sent as seven 0s followed by a 1.
- NRZI encoding: a 0 toggles the line state, a 1 holds it.
  - Idle/J is d_plus=1, d_minus=0. K is d_plus=0, d_minus=1.
  - SE0 is d_plus=0, d_minus=0.
- Bit stuffing:
  - A counter counts consecutive 1s from the SYNC through the last CRC bit.
  - After the sixth consecutive 1, a stuffed 0 (a toggle) is inserted, and the counter clears.
  - A transmitted 0 also clears the counter.
  - A stuff bit that falls due after the final CRC bit is still sent, before EOP.
- CRC16:
  - Polynomial 0x8005, initial value 0xFFFF, computed over payload bits only (not the PID).
  - Transmitted as the one's complement, LSB first, 16 bits.
  - Stuffed bits are not fed into the CRC.
- Payload handshake:
  - At the start of each payload byte's first bit, the block asserts tx_data_ready for one cycle.
  - In that same cycle it loads tx_data and tx_last.
  - tx_data_valid must be high in that cycle.
  - The loaded byte with tx_last=1 is the final byte; CRC follows it.
- Underrun: if tx_data_valid is low when a byte is due:
  - tx_error pulses.
  - No tx_data_ready pulse is issued.
  - The block goes directly to EOP_SE0, skipping the CRC.
  - tx_done still pulses at the end.
- EOP is SE0 for 2 bit times, then J for 1 bit time, then IDLE.
- tx_start is ignored while tx_busy=1 or while tx_done is pulsing.

## Timing
- Reset values: d_plus_out=1, d_minus_out=0, tx_busy=0, tx_done=0, tx_error=0, tx_data_ready=0. State is IDLE, the stuff counter is 0, and the CRC register is 0xFFFF.
- The first SYNC bit appears on the lines in the cycle after tx_start is accepted.
- Each bit, including stuffed bits, is held for exactly CLKS_PER_BIT cycles.
- Packet length, in bit times: 16 + 8·N (payload) + 16 (data only) + S (stuffed bits) + 3 (EOP).
- tx_done pulses in the cycle after the last EOP_J cycle. tx_busy drops in that same cycle.
- tx_start is accepted again from the following cycle.
- Asserting rst mid-packet forces the reset values immediately. The lines return to J and no tx_done is issued.

## Configuration
- USB_TX_CRC16_EN, defined:
  - CRC16 is generated and appended to data packets as described above.
- USB_TX_CRC16_EN, undefined:
  - The CRC logic is not compiled and the CRC state is skipped.
  - Data packets go from the last payload bit (plus any pending stuff bit) directly to EOP_SE0.
  - A zero-length packet becomes PID followed by EOP.

## Test plan
- ACK handshake (tx_pid=0xD2, packet_type=0):
  - Lines show KJKJKJKK, then the PID NRZI pattern, then SE0 ×2 and J.
  - tx_done pulses 19·8=152 cycles after tx_start+1. tx_data_ready never pulses.
- Zero-length DATA0 (0xC3, tx_nodata=1), CRC enabled:
  - The CRC field is 16 zeros, i.e. 16 consecutive line toggles.
  - Total 35 bit times. No tx_data_ready.
- DATA1 (0x4B), payload 0xFF,0xFF (tx_last on the second byte):
  - A stuffed toggle appears after every six consecutive 1s.
  - Bit-time count = 16 + 16 + 16 + S + 3, with S checked against a reference model.
  - tx_data_ready pulses exactly twice.
- Payload 0x01 then underrun (tx_data_valid low when the second byte is due):
  - tx_error pulses.
  - SE0 begins at the next bit boundary.
  - tx_done follows 3 bit times later. No CRC bits are sent.
- rst asserted in the middle of the DATA state:
  - Outputs go to J/idle values in the same cycle.
  - A subsequent tx_start sends a clean packet starting with SYNC.
- tx_start pulsed while tx_busy=1:
  - It is ignored. The line waveform is identical to the single-start case.
